// File: rtl/systolic_mm_ctrl_if.sv
// Host command / array datapath bundle for the systolic matrix-multiply sequencer.
// master = command issuer and datapath observer, slave = the sequencer itself.
interface systolic_mm_ctrl_if #(
  parameter int N  = 4,
  parameter int KW = 8,
  parameter int SW = $clog2(N)
);
  logic            start;
  logic [KW-1:0]   k_len;
  logic            busy;
  logic            done;
  logic            pe_clr_n;
  logic            op_rd_en;
  logic [KW-1:0]   op_rd_addr;
  logic [2*N-2:0]  diag_valid;
  logic [SW-1:0]   res_sel;
  logic            res_valid;

  modport master (
    output start, k_len,
    input  busy, done, pe_clr_n, op_rd_en, op_rd_addr, diag_valid, res_sel, res_valid
  );

  modport slave (
    input  start, k_len,
    output busy, done, pe_clr_n, op_rd_en, op_rd_addr, diag_valid, res_sel, res_valid
  );
endinterface

// File: rtl/systolic_mm_ctrl.sv
// Sequencer for an NxN systolic MAC array: clear, stream K operand reads,
// skew per-diagonal valids, wait for the wavefront to leave, then walk the
// result rows. Holds no matrix data; every output is a flop.
module systolic_mm_ctrl #(
  parameter int N  = 4,
  parameter int KW = 8,
  parameter int SW = $clog2(N)
) (
  input  logic                clk,
  input  logic                rst,
  systolic_mm_ctrl_if.slave   bus
);
  localparam int DW = 2 * N - 1;       // number of anti-diagonals
  localparam int CW = $clog2(2 * N);   // FLUSH/DRAIN counter reaches 2N-2

  typedef enum logic [2:0] {IDLE, CLEAR, FEED, FLUSH, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [KW-1:0]   kl_q, kl_d;         // latched K
  logic [KW-1:0]   addr_q, addr_d;     // k counter, doubles as op_rd_addr
  logic [CW-1:0]   cnt_q, cnt_d;       // FLUSH / DRAIN counter
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            clr_n_q, clr_n_d;
  logic            rd_en_q, rd_en_d;
  logic            rv_q, rv_d;
  logic [SW-1:0]   sel_q, sel_d;
  logic [DW-1:0]   chain_q, chain_d;   // bit 0 is v0 (read data valid), bit d is diagonal d

  // Next state, counters, and next-cycle outputs decoded from the next state
  always_comb begin
    state_d = state_q;
    kl_d    = kl_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start && bus.k_len != '0) begin
          kl_d    = bus.k_len;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        addr_d  = '0;
        state_d = FEED;
      end
      FEED: begin
        // compare against K-1 so K = 2^KW-1 never needs to reach 2^KW
        if (addr_q == kl_q - KW'(1)) begin
          cnt_d   = '0;
          state_d = FLUSH;
        end else begin
          addr_d = addr_q + KW'(1);
        end
      end
      FLUSH: begin
        if (cnt_q == CW'(2 * N - 2)) begin
          cnt_d   = '0;
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DRAIN: begin
        if (cnt_q == CW'(N - 1)) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d  = (state_d != IDLE);
    clr_n_d = (state_d != CLEAR);
    rd_en_d = (state_d == FEED);
    rv_d    = (state_d == DRAIN);
    sel_d   = rv_d ? cnt_d[SW-1:0] : '0;
    // read strobe delayed one cycle becomes v0, then one more cycle per diagonal
    chain_d = {chain_q[DW-2:0], rd_en_q};
  end

  // State and output registers; async active-low reset aborts any command
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      kl_q    <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      clr_n_q <= 1'b1;
      rd_en_q <= 1'b0;
      rv_q    <= 1'b0;
      sel_q   <= '0;
      chain_q <= '0;
    end else begin
      state_q <= state_d;
      kl_q    <= kl_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      clr_n_q <= clr_n_d;
      rd_en_q <= rd_en_d;
      rv_q    <= rv_d;
      sel_q   <= sel_d;
      chain_q <= chain_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pe_clr_n   = clr_n_q;
  assign bus.op_rd_en   = rd_en_q;
  assign bus.op_rd_addr = addr_q;
  assign bus.diag_valid = chain_q;
  assign bus.res_sel    = sel_q;
  assign bus.res_valid  = rv_q;
endmodule

// File: tb/tb_systolic_mm_ctrl.sv
// Bench for systolic_mm_ctrl: each accepted command pushes its full per-cycle
// output trace (built from the command timing) onto a queue; every cycle one
// entry is popped and compared against the outputs.
module tb_systolic_mm_ctrl;
  localparam int N  = 4;
  localparam int KW = 8;
  localparam int SW = $clog2(N);
  localparam int DW = 2 * N - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  systolic_mm_ctrl_if #(.N(N), .KW(KW), .SW(SW)) bus ();
  systolic_mm_ctrl #(.N(N), .KW(KW), .SW(SW)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic          busy;
    logic          done;
    logic          clr_n;
    logic          rd_en;
    logic [KW-1:0] addr;
    logic [DW-1:0] diag;
    logic          rv;
    logic [SW-1:0] sel;
  } exp_t;

  typedef struct {
    int k;
    int lat;   // expected start-to-done cycles, -1 = no command
  } vec_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   done_cyc = 0;
  int   t0_cyc = 0;

  // Per-cycle expectation for cycle offset t after acceptance of a K command
  function automatic exp_t trace_at(int k, int t);
    exp_t e;
    e.busy  = (t <= k + 3 * N);
    e.done  = (t == k + 3 * N + 1);
    e.clr_n = (t != 1);
    e.rd_en = (t >= 2 && t <= k + 1);
    e.addr  = KW'(t - 2);
    for (int d = 0; d < DW; d++) e.diag[d] = (t >= 3 + d && t <= k + 2 + d);
    e.rv    = (t >= k + 2 * N + 1 && t <= k + 3 * N);
    e.sel   = SW'(t - (k + 2 * N + 1));
    return e;
  endfunction

  task automatic push_cmd(int k);
    for (int t = 1; t <= k + 3 * N + 1; t++) q.push_back(trace_at(k, t));
  endtask

  task automatic check(string name, logic ok, string got, string want);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s cyc=%0d got %s want %s", name, cyc, got, want);
    end
  endtask

  // Sample at negedge, compare against the scoreboard, model start acceptance
  task automatic monitor();
    exp_t e, a;
    logic ok;
    a = '{bus.busy, bus.done, bus.pe_clr_n, bus.op_rd_en, bus.op_rd_addr,
          bus.diag_valid, bus.res_valid, bus.res_sel};
    if (!rst) begin
      q.delete();
      e = '{1'b0, 1'b0, 1'b1, 1'b0, '0, '0, 1'b0, '0};
      check("reset_vals", a == e, $sformatf("%h", a), $sformatf("%h", e));
    end else begin
      if (q.size() > 0) e = q.pop_front();
      else e = '{1'b0, 1'b0, 1'b1, 1'b0, '0, '0, 1'b0, '0};
      ok = (a.busy == e.busy) && (a.done == e.done) && (a.clr_n == e.clr_n) &&
           (a.rd_en == e.rd_en) && (a.diag == e.diag) && (a.rv == e.rv) &&
           (!e.rd_en || a.addr == e.addr) && (!e.rv || a.sel == e.sel);
      check("cycle_trace", ok,
            $sformatf("busy=%b done=%b clr_n=%b rd=%b addr=%0d diag=%b rv=%b sel=%0d",
                      a.busy, a.done, a.clr_n, a.rd_en, a.addr, a.diag, a.rv, a.sel),
            $sformatf("busy=%b done=%b clr_n=%b rd=%b addr=%0d diag=%b rv=%b sel=%0d",
                      e.busy, e.done, e.clr_n, e.rd_en, e.addr, e.diag, e.rv, e.sel));
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (bus.start && bus.k_len != '0 && q.size() == 0) begin
        push_cmd(int'(bus.k_len));
        t0_cyc = cyc;
      end
    end
    cyc++;
  endtask

  // One clock: check outputs mid-cycle, return just after the next rising edge
  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  // Issue one start pulse and wait (bounded) for its done
  task automatic run_cmd(int k, int lat);
    int d0, i;
    d0 = done_cnt;
    bus.start = 1'b1;
    bus.k_len = KW'(k);
    tick();
    bus.start = 1'b0;
    bus.k_len = KW'($urandom_range(1, 255));
    for (i = 0; i < 400 && done_cnt == d0; i++) tick();
    if (lat < 0) begin
      for (int j = 0; j < 20; j++) tick();
      check("no_done_k0", done_cnt == d0, $sformatf("%0d", done_cnt - d0), "0");
    end else begin
      check("latency", done_cnt == d0 + 1 && done_cyc - t0_cyc == lat,
            $sformatf("%0d (dones %0d)", done_cyc - t0_cyc, done_cnt - d0),
            $sformatf("%0d (dones 1)", lat));
      tick();
    end
  endtask

  vec_t vecs[5];
  int   d0;

  initial begin
    vecs[0] = '{3, 16};
    vecs[1] = '{1, 14};
    vecs[2] = '{255, 268};
    vecs[3] = '{2, 15};
    vecs[4] = '{0, -1};

    bus.start = 1'b0;
    bus.k_len = '0;
    tick();
    tick();
    rst = 1'b1;
    tick();

    for (int v = 0; v < 5; v++) run_cmd(vecs[v].k, vecs[v].lat);

    // start held every cycle with changing k_len: one done per command, and
    // the start seen in the done cycle launches the next command
    d0 = done_cnt;
    bus.start = 1'b1;
    bus.k_len = 8'd3;
    for (int i = 0; i < 100 && done_cnt == d0; i++) begin
      tick();
      bus.k_len = KW'($urandom_range(1, 6));
    end
    bus.start = 1'b0;
    check("one_done_first", done_cnt == d0 + 1, $sformatf("%0d", done_cnt - d0), "1");
    for (int i = 0; i < 100 && done_cnt == d0 + 1; i++) tick();
    check("second_cmd_done", done_cnt == d0 + 2, $sformatf("%0d", done_cnt - d0), "2");
    tick();

    // reset during FEED at k=1, released two cycles later
    d0 = done_cnt;
    bus.start = 1'b1;
    bus.k_len = 8'd5;
    tick();              // T0
    bus.start = 1'b0;
    tick();              // T1 CLEAR
    tick();              // T2 k=0
    rst = 1'b0;          // asserted during T3 (k=1)
    tick();
    tick();
    rst = 1'b1;
    for (int i = 0; i < 30; i++) tick();
    check("no_done_after_abort", done_cnt == d0, $sformatf("%0d", done_cnt - d0), "0");
    run_cmd(3, 16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
